gpu_cmd_feeder: RTL and testbench



---
 rtl/gpu_cmd_feeder_if.sv | 39 +++
 rtl/gpu_cmd_feeder.sv | 116 +++++++++++
 tb/tb_gpu_cmd_feeder.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/gpu_cmd_feeder_if.sv
// gpu_cmd_feeder_if: CPU write port, status flags and GPU
// cpuline bundle for the command feeder.
interface gpu_cmd_feeder_if #(
  parameter int AW = 3
);
  logic          wr_en;
  logic [7:0]    wr_cmd;
  logic [15:0]   wr_param;
  logic          ready;
  logic [AW:0]   level;
  logic          busy;
  logic          err_opcode;
  logic          err_ovf;
  logic [15:0]   cpuline;

  modport master (
    output wr_en,
    output wr_cmd,
    output wr_param,
    input  ready,
    input  level,
    input  busy,
    input  err_opcode,
    input  err_ovf,
    input  cpuline
  );

  modport slave (
    input  wr_en,
    input  wr_cmd,
    input  wr_param,
    output ready,
    output level,
    output busy,
    output err_opcode,
    output err_ovf,
    output cpuline
  );
endinterface

// File: rtl/gpu_cmd_feeder.sv
// gpu_cmd_feeder: FIFO of (opcode, param) pairs serialised
// onto cpuline as 3-word command / 2-word idle frames.
module gpu_cmd_feeder #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic clk,
  input  logic clr,
  gpu_cmd_feeder_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE0,
    IDLE1,
    CMD,
    PARAM,
    GAP
  } state_t;

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  state_t state;
  state_t state_nx;

  logic [2:0]    op_mem  [DEPTH];
  logic [15:0]   prm_mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic [15:0]   stage;
  logic [15:0]   line;
  logic [15:0]   line_nx;
  logic          err_op;
  logic          err_of;

  logic legal;
  logic ready;
  logic push;
  logic pop;
  logic at_bound;

  assign legal = (bus.wr_cmd >= 8'hC0) &&
                 (bus.wr_cmd <= 8'hC6);
  // full/empty come from the count, never from pointers
  assign ready    = count < FULL;
  assign push     = bus.wr_en && legal && ready;
  assign at_bound = (state == IDLE1) || (state == GAP);
  assign pop      = at_bound && (count != '0);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE0:   state_nx = IDLE1;
      IDLE1:   state_nx = pop ? CMD : IDLE0;
      CMD:     state_nx = PARAM;
      PARAM:   state_nx = GAP;
      GAP:     state_nx = pop ? CMD : IDLE0;
      default: state_nx = IDLE0;
    endcase
  end

  always_comb begin
    line_nx = '0;
    if (pop) begin
      line_nx = {8'h00, 5'b11000, op_mem[rd_ptr]};
    end else if (state == CMD) begin
      line_nx = stage;
    end
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      state  <= IDLE0;
      line   <= '0;
      stage  <= '0;
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      err_op <= 1'b0;
      err_of <= 1'b0;
    end else begin
      state <= state_nx;
      line  <= line_nx;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
        stage  <= prm_mem[rd_ptr];
      end
      if (push && !pop) begin
        count <= count + (AW+1)'(1);
      end else if (pop && !push) begin
        count <= count - (AW+1)'(1);
      end
      if (bus.wr_en && !legal) err_op <= 1'b1;
      if (bus.wr_en && legal && !ready) err_of <= 1'b1;
    end
  end

  // opcode index is the low 3 bits of 0xC0..0xC6
  always_ff @(posedge clk) begin
    if (clr && push) begin
      op_mem[wr_ptr]  <= bus.wr_cmd[2:0];
      prm_mem[wr_ptr] <= bus.wr_param;
    end
  end

  assign bus.ready      = ready;
  assign bus.level      = count;
  assign bus.busy       = (state == CMD) ||
                          (state == PARAM) ||
                          (state == GAP);
  assign bus.err_opcode = err_op;
  assign bus.err_ovf    = err_of;
  assign bus.cpuline    = line;

endmodule

// File: tb/tb_gpu_cmd_feeder.sv
// tb_gpu_cmd_feeder: directed steps with a frame scoreboard
// checking every cpuline word against queued writes.
module tb_gpu_cmd_feeder;

  logic clk = 1'b0;
  logic clr = 1'b0;

  always #5 clk = ~clk;

  gpu_cmd_feeder_if #(.AW(3)) bus ();

  gpu_cmd_feeder #(
    .DEPTH(8),
    .AW(3)
  ) dut (
    .clk(clk),
    .clr(clr),
    .bus(bus)
  );

  typedef struct {
    logic [7:0]  op;
    logic [15:0] prm;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  int   checks = 0;
  int   errors = 0;
  int   phase = 0;
  int   frames = 0;
  int   busy_cyc = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!clr) begin
      q.delete();
      phase = 0;
    end else if (bus.busy) begin
      busy_cyc++;
      case (phase)
        0: begin
          chk("frame_expected", 32'(q.size() > 0), 32'd1);
          if (q.size() > 0) cur = q.pop_front();
          else cur = exp_t'{8'h00, 16'h0000};
          chk("op_word", 32'(bus.cpuline), 32'(cur.op));
          frames++;
          phase = 1;
        end
        1: begin
          chk("param_word", 32'(bus.cpuline), 32'(cur.prm));
          phase = 2;
        end
        default: begin
          chk("gap_word", 32'(bus.cpuline), 32'h0);
          phase = 0;
        end
      endcase
    end else begin
      chk("idle_word", 32'(bus.cpuline), 32'h0);
      chk("frame_cut", 32'(phase), 32'd0);
      phase = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    clr = 1'b0;
    bus.wr_en = 1'b0;
    repeat (n) tick();
    clr = 1'b1;
  endtask

  task automatic wr(input logic [7:0] c,
                    input logic [15:0] p,
                    input bit acc);
    bus.wr_en    = 1'b1;
    bus.wr_cmd   = c;
    bus.wr_param = p;
    if (acc) q.push_back(exp_t'{c, p});
    tick();
    bus.wr_en = 1'b0;
  endtask

  task automatic drain(input int maxc);
    int n = 0;
    while ((bus.level != 0 || bus.busy || phase != 0) &&
           n < maxc) begin
      tick();
      n++;
    end
    chk("drain_timeout", 32'(n < maxc), 32'd1);
    repeat (2) tick();
  endtask

  int f0;
  int b0;
  logic [7:0] c;

  initial begin
    bus.wr_en    = 1'b0;
    bus.wr_cmd   = 8'h00;
    bus.wr_param = 16'h0000;

    do_reset(2);
    chk("rst_cpuline", 32'(bus.cpuline), 32'h0);
    chk("rst_level", 32'(bus.level), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_err_op", 32'(bus.err_opcode), 32'h0);
    chk("rst_err_ovf", 32'(bus.err_ovf), 32'h0);
    chk("rst_ready", 32'(bus.ready), 32'h1);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("quiet_line", 32'(bus.cpuline), 32'h0);
    end

    do_reset(1);
    wr(8'hC1, 16'h0041, 1'b1);
    chk("s_level1", 32'(bus.level), 32'd1);
    chk("s_wait", 32'(bus.cpuline), 32'h0);
    tick();
    chk("s_op", 32'(bus.cpuline), 32'h00C1);
    chk("s_busy", 32'(bus.busy), 32'h1);
    chk("s_level0", 32'(bus.level), 32'd0);
    tick();
    chk("s_prm", 32'(bus.cpuline), 32'h0041);
    tick();
    chk("s_gap", 32'(bus.cpuline), 32'h0);
    tick();
    chk("s_idle_busy", 32'(bus.busy), 32'h0);
    tick();
    wr(8'hC6, 16'hFFFF, 1'b1);
    chk("l2_level", 32'(bus.level), 32'd1);
    tick();
    chk("l2_wait", 32'(bus.cpuline), 32'h0);
    tick();
    chk("l2_op", 32'(bus.cpuline), 32'h00C6);
    drain(20);
    chk("s_q_empty", 32'(q.size()), 32'd0);

    do_reset(1);
    f0 = frames;
    b0 = busy_cyc;
    wr(8'hC5, 16'h0000, 1'b1);
    wr(8'hC1, 16'h0048, 1'b1);
    wr(8'hC1, 16'h0049, 1'b1);
    drain(40);
    chk("b_frames", 32'(frames - f0), 32'd3);
    chk("b_busy_cyc", 32'(busy_cyc - b0), 32'd9);
    chk("b_q_empty", 32'(q.size()), 32'd0);

    do_reset(1);
    f0 = frames;
    for (int i = 0; i < 12; i++) begin
      c = 8'hC0 + 8'(i % 7);
      wr(c, 16'(16'h0A00 + i), 1'b1);
    end
    chk("o_level8", 32'(bus.level), 32'd8);
    chk("o_ready0", 32'(bus.ready), 32'h0);
    chk("o_ovf_pre", 32'(bus.err_ovf), 32'h0);
    wr(8'hC2, 16'hDEAD, 1'b0);
    chk("o_ovf", 32'(bus.err_ovf), 32'h1);
    chk("o_level_hold", 32'(bus.level), 32'd8);
    drain(100);
    chk("o_frames", 32'(frames - f0), 32'd12);
    chk("o_ovf_sticky", 32'(bus.err_ovf), 32'h1);
    chk("o_ready1", 32'(bus.ready), 32'h1);

    do_reset(1);
    f0 = frames;
    wr(8'h55, 16'h1234, 1'b0);
    chk("i_err_op", 32'(bus.err_opcode), 32'h1);
    chk("i_level0", 32'(bus.level), 32'd0);
    wr(8'hC7, 16'h0001, 1'b0);
    wr(8'hBF, 16'h0002, 1'b0);
    wr(8'hC4, 16'h0003, 1'b1);
    chk("i_level1", 32'(bus.level), 32'd1);
    chk("i_no_ovf", 32'(bus.err_ovf), 32'h0);
    tick();
    chk("i_level_peak", 32'(bus.level), 32'd1);
    tick();
    chk("i_op", 32'(bus.cpuline), 32'h00C4);
    chk("i_level_end", 32'(bus.level), 32'd0);
    drain(20);
    chk("i_frames", 32'(frames - f0), 32'd1);
    chk("i_err_sticky", 32'(bus.err_opcode), 32'h1);

    do_reset(1);
    wr(8'h10, 16'h0000, 1'b0);
    tick();
    for (int i = 0; i < 5; i++) begin
      c = 8'hC0 + 8'(i);
      wr(c, 16'(16'h0100 + i), 1'b1);
    end
    tick();
    chk("m_param", 32'(bus.cpuline), 32'h0101);
    chk("m_level3", 32'(bus.level), 32'd3);
    chk("m_err_op", 32'(bus.err_opcode), 32'h1);
    do_reset(1);
    chk("m_line", 32'(bus.cpuline), 32'h0);
    chk("m_level", 32'(bus.level), 32'd0);
    chk("m_err_op0", 32'(bus.err_opcode), 32'h0);
    chk("m_err_ovf0", 32'(bus.err_ovf), 32'h0);
    chk("m_busy", 32'(bus.busy), 32'h0);
    chk("m_ready", 32'(bus.ready), 32'h1);
    f0 = frames;
    wr(8'hC0, 16'h0000, 1'b1);
    drain(20);
    chk("m_frames", 32'(frames - f0), 32'd1);
    chk("m_q_empty", 32'(q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
